// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares one SRAM-like memory port between the IF-stage fetch
//               and the MEM-stage load/store. The arbiter grants one requester
//               at a time, runs the address/data handshakes and returns the
//               read word with a one-cycle done pulse. It also derives the bus
//               transfer size and raises the pipeline stall.
//
// Ports       : clk, rst                        clock, sync active-high reset
//               inst_req/addr/rdata/done        instruction fetch side
//               data_req/wr/wen/addr/wdata      load/store side
//               data_rdata/done                 load/store completion
//               stall                           pipeline stall (combinational)
//               m_req/wr/size/addr/wdata        memory bridge request side
//               m_addr_ok/data_ok/rdata         memory bridge response side
//
// Options     : MEM_ARB_RR_EN  defined   -> round-robin tie break
//                              undefined -> data always beats fetch
//
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_done,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [3:0]    data_wen,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_done,

    output logic          stall,

    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_D_ADDR = 3'd1;
    localparam logic [2:0] S_D_WAIT = 3'd2;
    localparam logic [2:0] S_I_ADDR = 3'd3;
    localparam logic [2:0] S_I_WAIT = 3'd4;

    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Loads and fetches are always issued as aligned word reads.
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

    logic [2:0] state;
    logic       pick_data;
    logic       faulting_store;
    logic [1:0] wen_size;

`ifdef MEM_ARB_RR_EN
    // 1 = data was the last requester granted; reset favours data next.
    logic last_grant_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_data <= 1'b0;
        end else if (state == S_IDLE && (data_req || inst_req)) begin
            last_grant_data <= pick_data;
        end
    end

    assign pick_data = data_req && !(inst_req && last_grant_data);
`else
    assign pick_data = data_req;
`endif

    // A store with no byte lanes enabled never reaches the bus.
    assign faulting_store = data_wr && (data_wen == 4'b0000);

    assign stall = (inst_req && !inst_done) || (data_req && !data_done);

    always_comb begin
        wen_size = SIZE_WORD;
        case (data_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_size = 2'd0;
            4'b0011, 4'b1100:                   wen_size = 2'd1;
            default:                            wen_size = SIZE_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            m_req      <= 1'b0;
            m_wr       <= 1'b0;
            m_size     <= SIZE_WORD;
            m_addr     <= '0;
            m_wdata    <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
        end else begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_data) begin
                        if (faulting_store) begin
                            data_done <= 1'b1;
                        end else begin
                            state   <= S_D_ADDR;
                            m_req   <= 1'b1;
                            m_wr    <= data_wr;
                            m_size  <= data_wr ? wen_size : SIZE_WORD;
                            m_addr  <= data_wr ? data_addr : (data_addr & WORD_MASK);
                            m_wdata <= data_wdata;
                        end
                    end else if (inst_req) begin
                        state   <= S_I_ADDR;
                        m_req   <= 1'b1;
                        m_wr    <= 1'b0;
                        m_size  <= SIZE_WORD;
                        m_addr  <= inst_addr & WORD_MASK;
                        m_wdata <= '0;
                    end
                end
                S_D_ADDR: begin
                    if (m_addr_ok) begin
                        m_req <= 1'b0;
                        if (m_data_ok) begin
                            state      <= S_IDLE;
                            data_rdata <= m_rdata;
                            data_done  <= 1'b1;
                        end else begin
                            state <= S_D_WAIT;
                        end
                    end
                end
                S_D_WAIT: begin
                    if (m_data_ok) begin
                        state      <= S_IDLE;
                        data_rdata <= m_rdata;
                        data_done  <= 1'b1;
                    end
                end
                S_I_ADDR: begin
                    if (m_addr_ok) begin
                        m_req <= 1'b0;
                        if (m_data_ok) begin
                            state      <= S_IDLE;
                            inst_rdata <= m_rdata;
                            inst_done  <= 1'b1;
                        end else begin
                            state <= S_I_WAIT;
                        end
                    end
                end
                S_I_WAIT: begin
                    if (m_data_ok) begin
                        state      <= S_IDLE;
                        inst_rdata <= m_rdata;
                        inst_done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               reference model predicts every output each cycle; directed
//               tests add hand-computed literal expectations.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        stall;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    wire         m_addr_ok;
    wire         m_data_ok;
    logic [31:0] b_rdata = '0;

    // Bridge responder and manual override
    logic bridge_en = 1'b1;
    logic b_aok = 1'b0, b_dok = 1'b0, man_aok = 1'b0, man_dok = 1'b0;
    int   b_alat = 0, b_dlat = 0, b_acnt = 0, b_dcnt = 0;
    bit   b_wait = 0;
    assign m_addr_ok = bridge_en ? b_aok : man_aok;
    assign m_data_ok = bridge_en ? b_dok : man_dok;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
        .stall(stall),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout t=%0t", nm, $time);
    endtask

    // Simple bridge: addr_ok after b_alat cycles of m_req, data_ok b_dlat
    // cycles after addr_ok (0 = same cycle).
    always @(posedge clk) begin
        #1;
        b_aok = 1'b0;
        b_dok = 1'b0;
        if (rst) begin
            b_acnt = 0;
            b_wait = 0;
        end else if (b_wait) begin
            b_dcnt++;
            if (b_dcnt >= b_dlat) begin
                b_dok  = 1'b1;
                b_wait = 0;
            end
        end else if (m_req) begin
            if (b_acnt >= b_alat) begin
                b_aok  = 1'b1;
                b_acnt = 0;
                if (b_dlat == 0) b_dok = 1'b1;
                else begin
                    b_wait = 1;
                    b_dcnt = 0;
                end
            end else begin
                b_acnt++;
            end
        end else begin
            b_acnt = 0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction record
    // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          busy;
        bit          is_data;
        bit          addr_taken;
    } txn_t;

    txn_t        cur;
    bit          e_mreq, e_mwr, e_idone, e_ddone, e_last_data;
    logic [1:0]  e_msize;
    logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;

    function automatic logic [1:0] size_of(input logic [3:0] wen);
        int n = $countones(wen);
        if (n == 1) return 2'd0;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    always @(posedge clk) begin
        bit pick_data;
        if (rst) begin
            cur = '{0, 0, 0};
            e_mreq = 0; e_mwr = 0; e_msize = 2'd2; e_maddr = 0; e_mwdata = 0;
            e_idone = 0; e_ddone = 0; e_irdata = 0; e_drdata = 0; e_last_data = 0;
        end else begin
            e_idone = 0;
            e_ddone = 0;
            if (!cur.busy) begin
                pick_data = data_req && !(RR && inst_req && e_last_data);
                if (pick_data && data_wr && data_wen == 4'b0000) begin
                    e_ddone = 1;
                    e_last_data = 1;
                end else if (pick_data || inst_req) begin
                    cur = '{1, pick_data, 0};
                    e_last_data = pick_data;
                    e_mreq = 1;
                    if (pick_data) begin
                        e_mwr    = data_wr;
                        e_msize  = data_wr ? size_of(data_wen) : 2'd2;
                        e_maddr  = data_wr ? data_addr : (data_addr / 4) * 4;
                        e_mwdata = data_wdata;
                    end else begin
                        e_mwr = 0; e_msize = 2'd2; e_mwdata = 0;
                        e_maddr = (inst_addr / 4) * 4;
                    end
                end
            end else begin
                if (!cur.addr_taken && m_addr_ok) begin
                    cur.addr_taken = 1;
                    e_mreq = 0;
                end
                if (cur.addr_taken && m_data_ok) begin
                    if (cur.is_data) begin e_ddone = 1; e_drdata = b_rdata; end
                    else begin e_idone = 1; e_irdata = b_rdata; end
                    cur.busy = 0;
                end
            end
        end
        started = 1;
    end

    // Compare process
    always @(negedge clk) begin
        if (started) begin
            chk("m_req", m_req, e_mreq);
            chk("m_wr", m_wr, e_mwr);
            chk("m_size", m_size, e_msize);
            chk("m_addr", m_addr, e_maddr);
            chk("m_wdata", m_wdata, e_mwdata);
            chk("inst_done", inst_done, e_idone);
            chk("data_done", data_done, e_ddone);
            chk("inst_rdata", inst_rdata, e_irdata);
            chk("data_rdata", data_rdata, e_drdata);
            chk("stall", stall, (inst_req && !e_idone) || (data_req && !e_ddone));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic fetch(input logic [31:0] addr, input logic [31:0] rd, input int alat, input int dlat,
                         output int cyc, output logic [31:0] got);
        b_alat = alat; b_dlat = dlat; b_rdata = rd;
        inst_req = 1'b1; inst_addr = addr;
        cyc = 0; got = '0;
        forever begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) inst_addr = ~addr;
            if (inst_done) begin got = inst_rdata; break; end
            if (cyc > 30) begin timeout("fetch"); break; end
        end
        inst_req = 1'b0;
    endtask

    task automatic data_op(input logic wr, input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int alat, input int dlat,
                           output int cyc, output bit saw_req, output logic [1:0] sz,
                           output logic [31:0] ad, output logic [31:0] got);
        b_alat = alat; b_dlat = dlat; b_rdata = rd;
        data_req = 1'b1; data_wr = wr; data_wen = wen; data_addr = addr; data_wdata = wd;
        cyc = 0; saw_req = 0; sz = 2'd3; ad = '0; got = '0;
        forever begin
            @(posedge clk); #1; cyc++;
            if (m_req && !saw_req) begin saw_req = 1; sz = m_size; ad = m_addr; end
            if (cyc == 1) begin data_addr = ~addr; data_wdata = ~wd; end
            if (data_done) begin got = data_rdata; break; end
            if (cyc > 30) begin timeout("data_op"); break; end
        end
        data_req = 1'b0;
    endtask

    initial begin
        int          cyc;
        bit          saw, seen_req, first_data, got_d, got_i;
        logic [1:0]  sz;
        logic [31:0] ad, got, prev;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_size", m_size, 32'd2);
        chk("rst_m_req", m_req, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: fetch only
        fetch(32'hBFC00000, 32'h3C1D8000, 0, 2, cyc, got);
        chk("t1_latency", cyc, 32'd4);
        chk("t1_rdata", got, 32'h3C1D8000);

        // 2: simultaneous store byte and fetch
        b_alat = 0; b_dlat = 1; b_rdata = 32'h24080001;
        data_req = 1; data_wr = 1; data_wen = 4'b0100; data_addr = 32'h80001002; data_wdata = 32'hABABABAB;
        inst_req = 1; inst_addr = 32'hBFC00004;
        seen_req = 0; first_data = 0; got_d = 0; got_i = 0;
        for (int i = 0; i < 40 && !(got_d && got_i); i++) begin
            @(posedge clk); #1;
            if (m_req && !seen_req) begin
                seen_req = 1;
                chk("t2_m_wr", m_wr, 32'd1);
                chk("t2_m_size", m_size, 32'd0);
                chk("t2_m_addr", m_addr, 32'h80001002);
            end
            if (data_done) begin if (!got_i) first_data = 1; got_d = 1; data_req = 0; end
            if (inst_done) begin got_i = 1; inst_req = 0; end
        end
        if (!(got_d && got_i)) timeout("t2_both");
        chk("t2_data_first", first_data, 32'd1);
        data_req = 0; inst_req = 0;
        @(posedge clk); #1;

        // 3: load half -> aligned word read, raw data
        data_op(0, 4'b0011, 32'h80000006, 32'h0, 32'h12345678, 1, 1, cyc, saw, sz, ad, got);
        chk("t3_m_addr", ad, 32'h80000004);
        chk("t3_m_size", sz, 32'd2);
        chk("t3_rdata", got, 32'h12345678);
        chk("t3_latency", cyc, 32'd4);

        // Size/addr for other store widths
        data_op(1, 4'b1100, 32'h80000012, 32'h55665566, 32'h0BADF00D, 0, 3, cyc, saw, sz, ad, got);
        chk("sh_size", sz, 32'd1);
        chk("sh_addr", ad, 32'h80000012);
        data_op(1, 4'b1111, 32'h80000010, 32'h11223344, 32'h0, 2, 1, cyc, saw, sz, ad, got);
        chk("sw_size", sz, 32'd2);
        fetch(32'h80000103, 32'hCAFEF00D, 1, 0, cyc, got);
        chk("fetch_unaligned_rdata", got, 32'hCAFEF00D);

        // 4: faulting store
        prev = data_rdata;
        data_op(1, 4'b0000, 32'h80000020, 32'h99999999, 32'h77777777, 0, 0, cyc, saw, sz, ad, got);
        chk("t4_latency", cyc, 32'd1);
        chk("t4_no_req", saw, 32'd0);
        chk("t4_rdata_kept", got, prev);

        // 5: addr_ok and data_ok together
        data_op(0, 4'b1111, 32'h80000030, 32'h0, 32'hA5A5A5A5, 0, 0, cyc, saw, sz, ad, got);
        chk("t5_latency", cyc, 32'd2);
        chk("t5_rdata", got, 32'hA5A5A5A5);

        // 6: reset during D_WAIT, late data_ok ignored
        bridge_en = 0; b_rdata = 32'hDEADBEEF;
        data_req = 1; data_wr = 0; data_wen = 4'b1111; data_addr = 32'h80000040;
        @(posedge clk); #1; man_aok = 1;
        @(posedge clk); #1; man_aok = 0; rst = 1; data_req = 0;
        @(posedge clk); #1; rst = 0; man_dok = 1;
        chk("t6_m_req", m_req, 32'd0);
        chk("t6_m_size", m_size, 32'd2);
        chk("t6_m_addr", m_addr, 32'd0);
        chk("t6_data_rdata", data_rdata, 32'd0);
        @(posedge clk); #1; man_dok = 0;
        chk("t6_no_done", data_done, 32'd0);
        @(posedge clk); #1;
        chk("t6_no_done2", data_done, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
